// File: rtl/slicel_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// slicel_cfg_loader_if
// Word-serial configuration stream carried on a valid/ready handshake.
//   cfg_valid : source has a word on cfg_data
//   cfg_data  : bitstream word, WORD_W bits
//   cfg_ready : sink takes the word on this clock edge
// A word moves on every rising edge where cfg_valid && cfg_ready.
// ---------------------------------------------------------------------------
interface slicel_cfg_loader_if #(
    parameter int WORD_W = 8
);
    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/slicel_cfg_loader.sv
// ---------------------------------------------------------------------------
// slicel_cfg_loader
// Assembles a word-serial bitstream into a shadow frame buffer for a column
// of slicel instances, checks a trailing XOR checksum and then commits the
// whole buffer to the live configuration bus in a single edge.
//
// Ports
//   cclk       : config clock, all state moves on its rising edge
//   rst        : asynchronous, active-high reset
//   i_start    : one-cycle request to begin or restart a load
//   cfg        : stream slave (cfg_valid / cfg_data in, cfg_ready out)
//   o_cfg_out  : committed configuration, slice i at [i*FRAME_BITS +: FRAME_BITS]
//   o_cen      : high while slices are in config mode
//   o_done     : high while a verified configuration is live
//   o_err      : high after a checksum failure until the next start
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no load in progress, waiting for start
// LOAD   | accepting data words into the shadow buffer
// CHECK  | next accepted word is the checksum
// ACTIVE | verified configuration committed, slices released
// ---------------------------------------------------------------------------
module slicel_cfg_loader #(
    parameter  int NUM_SLICES = 2,
    parameter  int FRAME_BITS = 143,
    parameter  int WORD_W     = 8,
    localparam int TOTAL_BITS = NUM_SLICES * FRAME_BITS
) (
    input  logic                  cclk,
    input  logic                  rst,
    input  logic                  i_start,
    slicel_cfg_loader_if.slave    cfg,
    output logic [TOTAL_BITS-1:0] o_cfg_out,
    output logic                  o_cen,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int NUM_WORDS = (TOTAL_BITS + WORD_W - 1) / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int IDX_W     = $clog2(TOTAL_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ACTIVE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_wcnt;
    logic [WORD_W-1:0]     r_xsum;
    logic [TOTAL_BITS-1:0] r_shadow;
    logic [TOTAL_BITS-1:0] w_shadow_nxt;
    logic [TOTAL_BITS-1:0] r_cfg_out;
    logic                  r_cen;
    logic                  r_done;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_clear;
    logic                  w_load_word;
    logic                  w_commit;
    logic                  w_fail;

    // start has priority over the stream: a cycle that restarts never consumes.
    assign w_ready  = ((r_state == S_LOAD) || (r_state == S_CHECK)) && !i_start;
    assign w_accept = cfg.cfg_valid && w_ready;

    assign cfg.cfg_ready = w_ready;
    assign o_cfg_out     = r_cfg_out;
    assign o_cen         = r_cen;
    assign o_done        = r_done;
    assign o_err         = r_err;

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_load_word = 1'b0;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        case (r_state)
            S_IDLE, S_ACTIVE: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                    w_clear     = 1'b1;
                end
            end
            S_LOAD: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                    w_clear     = 1'b1;
                end else if (w_accept) begin
                    w_load_word = 1'b1;
                    if (r_wcnt == CNT_W'(NUM_WORDS - 1)) begin
                        w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                    w_clear     = 1'b1;
                end else if (w_accept) begin
                    if (cfg.cfg_data == r_xsum) begin
                        w_commit    = 1'b1;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_fail      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Drop the incoming word into its slot; bits of the final word that land
    // beyond TOTAL_BITS are padding and are simply not stored.
    always_comb begin
        int base;
        base         = int'(r_wcnt) * WORD_W;
        w_shadow_nxt = r_shadow;
        for (int b = 0; b < WORD_W; b++) begin
            if (base + b < TOTAL_BITS) begin
                w_shadow_nxt[IDX_W'(base + b)] = cfg.cfg_data[b];
            end
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_wcnt    <= '0;
            r_xsum    <= '0;
            r_shadow  <= '0;
            r_cfg_out <= '0;
            r_cen     <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_clear) begin
                r_wcnt <= '0;
                r_xsum <= '0;
                r_cen  <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_load_word) begin
                r_shadow <= w_shadow_nxt;
                r_wcnt   <= r_wcnt + CNT_W'(1);
                r_xsum   <= r_xsum ^ cfg.cfg_data;
            end
            if (w_commit) begin
                r_cfg_out <= r_shadow;
                r_cen     <= 1'b0;
                r_done    <= 1'b1;
            end
            if (w_fail) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/slicel_cfg_loader.md
# slicel_cfg_loader

Parametrised configuration loader for a column of `slicel` instances. It accepts a word-serial bitstream over a valid/ready handshake and assembles it into a shadow frame buffer. It verifies a trailing XOR checksum, then atomically commits the buffer to the live configuration bus. It owns the slices' `cen` (config-mode) line: `cen` is held high during loading and released only after a verified commit.

## Interface
- `NUM_SLICES`, 2, number of slices served
- `FRAME_BITS`, 143, config bits per slice; layout `[131:0]` LUT configs, `[133:132]` inter-LUT mux, `[134]` use_cc, `[142:135]` register init values
- `WORD_W`, 8, bitstream word width
- `TOTAL_BITS` (derived), `NUM_SLICES*FRAME_BITS`
- `NUM_WORDS` (derived), `ceil(TOTAL_BITS/WORD_W)`
- `cclk`  in  1  config clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request to begin, or restart, a load
- `cfg_valid`  in  1  `cfg_data` holds a word
- `cfg_data`  in  WORD_W  bitstream word
- `cfg_ready`  out  1  loader accepts a word this cycle
- `cfg_out`  out  TOTAL_BITS  committed config; slice i = `cfg_out[i*FRAME_BITS +: FRAME_BITS]`
- `cen`  out  1  high = slices in config mode, drives every slice's `cen`
- `done`  out  1  level, high while a verified config is active
- `err`  out  1  level, high after a checksum failure, until the next `start`

## Operation
- States: IDLE, LOAD, CHECK, ACTIVE. The state and a word counter `wcnt` (`clog2(NUM_WORDS+1)` bits) are registered.
- Handshake: a word is accepted on an edge where `cfg_valid && cfg_ready`.
  - `cfg_ready = (state==LOAD || state==CHECK) && !start`, combinational.
  - `cfg_valid` may toggle freely. Nothing is consumed without `cfg_ready`.
- Packing in LOAD: accepted word k is written to `shadow[k*WORD_W +: WORD_W]`, LSB first.
  - Bits beyond `TOTAL_BITS` in the last word are discarded.
  - Each accepted word XORs into running checksum `xsum` at full `WORD_W` width, pad bits included.
- Transitions:
  - IDLE/ACTIVE + `start` → LOAD. Clears `wcnt`, `xsum`, `done`, `err`; sets `cen`=1. `cfg_out` is unchanged.
  - LOAD: each accepted word increments `wcnt`. Acceptance of word `NUM_WORDS-1` → CHECK.
  - CHECK: the accepted word is the checksum.
    - If it equals `xsum`: `cfg_out` ← `shadow`, `cen` ← 0, `done` ← 1, → ACTIVE.
    - Otherwise: `err` ← 1, `cen` stays 1, `cfg_out` keeps its previous value, → IDLE.
  - LOAD/CHECK + `start` → abort and restart LOAD with cleared `wcnt`/`xsum`. The shadow contents are irrelevant because they will be overwritten.
- `shadow` is never visible on `cfg_out` except through a verified commit. A partial or failed load never reaches the slices.

## Timing
- Reset values: state IDLE; `cfg_out`=0, `shadow`=0, `wcnt`=0, `xsum`=0; `cen`=1, `done`=0, `err`=0, `cfg_ready`=0.
- Reset asserted mid-load or while ACTIVE returns immediately to the reset values, including `cfg_out`=0.
- `start` sampled at edge t: `cfg_ready` can be high from cycle t+1.
- Back-to-back streaming: one word per cycle. A full load takes `NUM_WORDS+1` accepting edges after `start`.
- Commit edge (checksum accepted): `cfg_out`, `cen`=0 and `done`=1 all update on that same edge. There are no extra cycles.
- `cen` rises on the edge that samples `start` while ACTIVE. `cfg_out` is held stable while `cen`=1.
- `start` asserted with `cfg_valid` high: no word is consumed that cycle.
- `start` held high for multiple cycles: each cycle restarts the load. Loading proceeds after `start` drops.

## Test plan
Use the defaults throughout: `NUM_WORDS`=36, plus 1 checksum word.
1. Reset, then `start`, then 36 words 0x00..0x23 back-to-back, then checksum = XOR of those words.
   - `cfg_out[7:0]`=0x00 and `cfg_out[15:8]`=0x01.
   - `cfg_out[285:280]` = low 6 bits of 0x23 = 6'b100011; the 2 pad bits are discarded.
   - `cen` 1→0 and `done`=1 on the checksum edge.
2. Same stream as scenario 1 with the checksum inverted.
   - `err`=1, `cen`=1, `done`=0, `cfg_out` still all-zero. The state returns to IDLE with `cfg_ready`=0.
3. From ACTIVE (after scenario 1), `start`, then load all-0xFF words plus checksum 0x00 (36 × 0xFF XOR to 0).
   - `cen`=1 and the old `cfg_out` are held throughout the load.
   - After commit, `cfg_out` is all ones, `cen`=0, `done`=1.
4. Insert random `cfg_valid` gaps; also assert `cfg_valid` during IDLE and ACTIVE.
   - Result is identical to scenario 1, and no word is consumed while `cfg_ready`=0.
5. Assert `start` after 10 words, then send a full correct load of 0x5A words plus checksum 0x00.
   - `cfg_out` is every byte 0x5A (top slice truncated). No residue from the aborted load.
6. Assert `rst` asynchronously between clock edges after word 20.
   - Outputs reach their reset values before the next edge. A fresh load afterwards commits correctly.
